ccff_chain_programmer: RTL

- Single-clock loader that drives the fabric configuration chain (ccff_head, prog_clk) from a host byte stream.
- Captures the bits that fall out of ccff_tail during the same pass, and returns them as a readback byte stream.
- Sits between the Tiny Tapeout user I/O logic and the FPGA fabric's configuration flip-flop chain.
- Asserts cfg_done when the chain is fully programmed.

---
 rtl/ccff_chain_programmer_pkg.sv | 21 ++
 rtl/ccff_phase_timer.sv | 25 ++
 rtl/ccff_chain_programmer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ccff_chain_programmer_pkg.sv
// Shared definitions for the configuration-chain programmer: FSM encoding,
// default chain length of the current fabric build, and a small next-state helper.
package ccff_chain_programmer_pkg;

    localparam int CHAIN_LEN_DEFAULT = 64;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        RB_PUSH  = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Where shifting continues once a bit has completed: refill when the byte is spent.
    function automatic state_t resume_state(input logic [3:0] bits_left);
        return (bits_left == 4'd0) ? FETCH : SHIFT_LO;
    endfunction

endpackage

// File: rtl/ccff_phase_timer.sv
// DIV-cycle down-counter timing one prog_clk phase; expire is high in the
// last cycle of the phase, load re-arms it for the next phase.
module ccff_phase_timer #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= 8'(DIV - 1);
        else if (cnt != 8'd0)
            cnt <= cnt - 8'd1;
    end

    assign expire = (cnt == 8'd0);

endmodule

// File: rtl/ccff_chain_programmer.sv
// Streams host bytes LSB-first into the fabric configuration chain while
// capturing ccff_tail into readback bytes; all chain-facing outputs are registered.
module ccff_chain_programmer
    import ccff_chain_programmer_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT,
    parameter int DIV       = 2,
    localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       cfg_done,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] rb_data,
    output logic       rb_valid,
    input  logic       rb_ready,
    output logic       prog_clk,
    output logic       ccff_head,
    input  logic       ccff_tail
);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [6:0]       in_sr;      // bits of the current byte still to be driven after ccff_head
    logic [3:0]       in_left;
    logic [7:0]       rb_sr;
    logic [3:0]       rb_cnt;
    logic             rb_final;
    logic             tmr_load;
    logic             tmr_expire;
    logic             last_bit;

    // Outside the shift phases the timer is held loaded so every phase starts full.
    assign tmr_load = !(state == SHIFT_LO || state == SHIFT_HI) || tmr_expire;
    assign last_bit = (bit_cnt + CNT_W'(1)) == CNT_W'(CHAIN_LEN);

    ccff_phase_timer #(.DIV(DIV)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            in_sr     <= '0;
            in_left   <= '0;
            rb_sr     <= '0;
            rb_cnt    <= '0;
            rb_final  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_done  <= 1'b0;
            in_ready  <= 1'b0;
            rb_valid  <= 1'b0;
            rb_data   <= '0;
            prog_clk  <= 1'b0;
            ccff_head <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cfg_done <= 1'b0;
                    bit_cnt  <= '0;
                    in_left  <= '0;
                    rb_sr    <= '0;
                    rb_cnt   <= '0;
                    busy     <= 1'b1;
                    in_ready <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: if (in_valid) begin
                    ccff_head <= in_data[0];
                    in_sr     <= in_data[7:1];
                    in_left   <= 4'd8;
                    in_ready  <= 1'b0;
                    state     <= SHIFT_LO;
                end
                SHIFT_LO: if (tmr_expire) begin
                    // Pre-edge chain output pairs with the bit about to be clocked in.
                    rb_sr[rb_cnt[2:0]] <= ccff_tail;
                    rb_cnt   <= rb_cnt + 4'd1;
                    prog_clk <= 1'b1;
                    state    <= SHIFT_HI;
                end
                SHIFT_HI: if (tmr_expire) begin
                    prog_clk  <= 1'b0;
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                    ccff_head <= in_sr[0];
                    in_sr     <= {1'b0, in_sr[6:1]};
                    in_left   <= in_left - 4'd1;
                    if (last_bit || rb_cnt == 4'd8) begin
                        rb_data  <= rb_sr;
                        rb_valid <= 1'b1;
                        rb_sr    <= '0;
                        rb_cnt   <= '0;
                        rb_final <= last_bit;
                        state    <= RB_PUSH;
                    end else begin
                        in_ready <= (in_left == 4'd1);
                        state    <= resume_state(in_left - 4'd1);
                    end
                end
                RB_PUSH: if (rb_ready) begin
                    rb_valid <= 1'b0;
                    if (rb_final) begin
                        done      <= 1'b1;
                        cfg_done  <= 1'b1;
                        busy      <= 1'b0;
                        ccff_head <= 1'b0;
                        state     <= DONE;
                    end else begin
                        in_ready <= (in_left == 4'd0);
                        state    <= resume_state(in_left);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
